// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver
//   SPI slave frame controller: mode 0 (CPOL=0, CPHA=0), MSB first.
//   The clock must run at least 8x faster than sclk.
//   - sclk, cs_n and mosi pass through 2-flop synchronisers. Edges of sclk and cs_n
//     are detected by comparing the synchronised value with its previous value.
//   - An IDLE/SHIFT/ABORT FSM frames the transfer and assembles MOSI bits into words.
//   - Completed words are held in an rx FIFO with a valid/ready interface.
//   - Host-supplied tx words are serialised onto MISO.
//
// Build option: define SPI_RX_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES
//   clocks with no sclk edge. Without it, no idle counter is built, ABORT is never
//   entered, and rx_timeout stays 0.
//
// Ports
//   clock, reset    system clock; synchronous active-high reset
//   sclk, cs_n      asynchronous SPI clock and active-low chip select
//   mosi            asynchronous SPI data in
//   miso            SPI data out; 0 outside an active frame
//   rx_data         FIFO head word, valid only while rx_valid=1
//   rx_valid        FIFO not empty
//   rx_ready        pops the FIFO head when rx_valid is also 1
//   rx_overflow     1-cycle pulse: a completed word was dropped because the FIFO was full
//   tx_data         next word to shift out on MISO
//   tx_valid        tx_data is available
//   tx_ready        1-cycle pulse: tx_data was loaded into the shifter
//   frame_active    FSM is in SHIFT
//   frame_done      1-cycle pulse when cs_n rises during SHIFT
//   frame_short     qualifies frame_done: a partial word was discarded
//   rx_timeout      1-cycle pulse: the frame was aborted by the idle timeout
module spi_frame_receiver #(
  parameter int unsigned WORD_BITS      = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overflow,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 frame_active,
  output logic                 frame_done,
  output logic                 frame_short,
  output logic                 rx_timeout
);

  localparam int unsigned CW = $clog2(WORD_BITS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  if (WORD_BITS < 2 || WORD_BITS > 32) begin : g_bad_word_bits
    $error("spi_frame_receiver: WORD_BITS must be in 2..32");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("spi_frame_receiver: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("spi_frame_receiver: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ABORT
  } state_e;

  // synchronisers and edge detectors
  logic sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_prev_q, sclk_prev_d;
  logic cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d, cs_prev_q, cs_prev_d;
  logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;

  // frame state
  state_e                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   words_done_q, words_done_d;
  logic [WORD_BITS-2:0]   shift_in_q, shift_in_d;
  logic [WORD_BITS-1:0]   tx_shift_q, tx_shift_d;

  // rx FIFO
  logic [WORD_BITS-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [WORD_BITS-1:0]   fifo_mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            fifo_cnt_q, fifo_cnt_d;

  // registered outputs
  logic rx_valid_q, rx_valid_d;
  logic rx_overflow_q, rx_overflow_d;
  logic tx_ready_q, tx_ready_d;
  logic frame_active_q, frame_active_d;
  logic frame_done_q, frame_done_d;
  logic frame_short_q, frame_short_d;
  logic rx_timeout_q, rx_timeout_d;

`ifdef SPI_RX_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  logic                 sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                 tx_load, push, pop, push_ok, fifo_full;
  logic [WORD_BITS-1:0] rx_word;

  always_comb begin
    sclk_meta_d = sclk;
    sclk_sync_d = sclk_meta_q;
    sclk_prev_d = sclk_sync_q;
    cs_meta_d   = cs_n;
    cs_sync_d   = cs_meta_q;
    cs_prev_d   = cs_sync_q;
    mosi_meta_d = mosi;
    mosi_sync_d = mosi_meta_q;

    sclk_rise = sclk_sync_q & ~sclk_prev_q;
    sclk_fall = ~sclk_sync_q & sclk_prev_q;
    cs_rise   = cs_sync_q & ~cs_prev_q;
    cs_fall   = ~cs_sync_q & cs_prev_q;

    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    words_done_d  = words_done_q;
    shift_in_d    = shift_in_q;
    tx_shift_d    = tx_shift_q;
    tx_load       = 1'b0;
    push          = 1'b0;
    rx_word       = {shift_in_q, mosi_sync_q};
    frame_done_d  = 1'b0;
    frame_short_d = 1'b0;
    rx_timeout_d  = 1'b0;
    tx_ready_d    = 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
    idle_cnt_d    = idle_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d      = ST_SHIFT;
          bit_cnt_d    = '0;
          words_done_d = 1'b0;
          tx_load      = 1'b1;
`ifdef SPI_RX_TIMEOUT_EN
          idle_cnt_d   = '0;
`endif
        end
      end
      ST_SHIFT: begin
`ifdef SPI_RX_TIMEOUT_EN
        idle_cnt_d = (sclk_rise | sclk_fall) ? '0 : idle_cnt_q + IW'(1);
`endif
        // cs_n rise wins over an sclk edge seen in the same cycle
        if (cs_rise) begin
          state_d       = ST_IDLE;
          frame_done_d  = 1'b1;
          frame_short_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          shift_in_d = rx_word[WORD_BITS-2:0];
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d    = '0;
            push         = 1'b1;
            words_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (sclk_fall) begin
          // a word boundary reloads the shifter; the very first fall shifts instead
          if (bit_cnt_q == '0 && words_done_q) begin
            tx_load = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[WORD_BITS-2:0], 1'b0};
          end
        end
`ifdef SPI_RX_TIMEOUT_EN
        else if (idle_cnt_q == IDLE_LAST) begin
          state_d      = ST_ABORT;
          rx_timeout_d = 1'b1;
        end
`endif
      end
      ST_ABORT: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tx_load) begin
      tx_shift_d = tx_valid ? tx_data : '0;
      tx_ready_d = tx_valid;
    end

    // rx FIFO: a push into a full FIFO still succeeds if a pop happens in the same cycle
    fifo_full     = (fifo_cnt_q == FULL_CNT);
    pop           = (fifo_cnt_q != '0) & rx_ready;
    push_ok       = push & (~fifo_full | pop);
    rx_overflow_d = push & fifo_full & ~pop;

    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push_ok) begin
      fifo_mem_d[wr_ptr_q] = rx_word;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (AW+1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (AW+1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    rx_valid_d     = (fifo_cnt_d != '0);
    frame_active_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_meta_q    <= 1'b0;
      sclk_sync_q    <= 1'b0;
      sclk_prev_q    <= 1'b0;
      cs_meta_q      <= 1'b0;
      cs_sync_q      <= 1'b0;
      cs_prev_q      <= 1'b0;
      mosi_meta_q    <= 1'b0;
      mosi_sync_q    <= 1'b0;
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      words_done_q   <= 1'b0;
      shift_in_q     <= '0;
      tx_shift_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_q     <= '0;
      rx_valid_q     <= 1'b0;
      rx_overflow_q  <= 1'b0;
      tx_ready_q     <= 1'b0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_short_q  <= 1'b0;
      rx_timeout_q   <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
      idle_cnt_q     <= '0;
`endif
    end else begin
      sclk_meta_q    <= sclk_meta_d;
      sclk_sync_q    <= sclk_sync_d;
      sclk_prev_q    <= sclk_prev_d;
      cs_meta_q      <= cs_meta_d;
      cs_sync_q      <= cs_sync_d;
      cs_prev_q      <= cs_prev_d;
      mosi_meta_q    <= mosi_meta_d;
      mosi_sync_q    <= mosi_sync_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      words_done_q   <= words_done_d;
      shift_in_q     <= shift_in_d;
      tx_shift_q     <= tx_shift_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
      rx_valid_q     <= rx_valid_d;
      rx_overflow_q  <= rx_overflow_d;
      tx_ready_q     <= tx_ready_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      frame_short_q  <= frame_short_d;
      rx_timeout_q   <= rx_timeout_d;
`ifdef SPI_RX_TIMEOUT_EN
      idle_cnt_q     <= idle_cnt_d;
`endif
    end
    // storage needs no reset: rx_data is only meaningful while rx_valid=1
    fifo_mem_q <= fifo_mem_d;
  end

  // both terms are flops; frame_active_q gates MISO low outside SHIFT, including ABORT
  assign miso         = frame_active_q & tx_shift_q[WORD_BITS-1];
  assign rx_data      = fifo_mem_q[rd_ptr_q];
  assign rx_valid     = rx_valid_q;
  assign rx_overflow  = rx_overflow_q;
  assign tx_ready     = tx_ready_q;
  assign frame_active = frame_active_q;
  assign frame_done   = frame_done_q;
  assign frame_short  = frame_short_q;
  assign rx_timeout   = rx_timeout_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Testbench for spi_frame_receiver (default build, WORD_BITS=8, FIFO_DEPTH=4).
// The SPI master runs sclk at clock/8. A background monitor logs FIFO pops and
// counts the output pulses. It also feeds tx words from a queue.
module tb_spi_frame_receiver;
  localparam int H = 4;  // half sclk period in clocks

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid, rx_overflow;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, frame_active, frame_done, frame_short, rx_timeout;

  spi_frame_receiver #(
    .WORD_BITS(8),
    .FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overflow(rx_overflow), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .frame_active(frame_active), .frame_done(frame_done),
    .frame_short(frame_short), .rx_timeout(rx_timeout)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // monitor
  logic [7:0] got_q[$];
  logic [7:0] txq[$];
  int ovf_n = 0, done_n = 0, short_n = 0, txr_n = 0, to_n = 0;
  logic fa_mid;

  initial begin
    forever begin
      @(negedge clock);
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_overflow) ovf_n++;
      if (frame_done) begin
        done_n++;
        if (frame_short) short_n++;
      end
      if (rx_timeout) to_n++;
      if (tx_ready) begin
        txr_n++;
        if (txq.size() > 0) void'(txq.pop_front());
      end
      tx_valid = (txq.size() != 0);
      tx_data  = (txq.size() != 0) ? txq[0] : 8'h00;
    end
  end

  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic m);
    mosi = b;
    clk(H);
    m = miso;
    sclk = 1'b1;
    clk(H);
    sclk = 1'b0;
  endtask

  task automatic run_frame(input int nbits, input logic [63:0] bits, output logic [63:0] mb);
    logic m;
    mb = '0;
    clk(2);
    cs_n = 1'b0;
    clk(H);
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[nbits-1-i], m);
      mb = {mb[62:0], m};
      if (i == 0) fa_mid = frame_active;
    end
    clk(H);
    cs_n = 1'b1;
    clk(8);
  endtask

  typedef struct {
    logic [15:0] mosi_w;
    logic [23:0] tx_w;
    int          ntx;
    logic [15:0] exp_miso;
    int          exp_txr;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[4];
    logic [63:0] mb;
    logic [23:0] t;
    logic        m;
    int          d0, s0, r0, o0, lat;

    vecs[0] = '{16'hA53C, 24'h000000, 0, 16'h0000, 0};
    vecs[1] = '{16'h00FF, 24'h817E00, 2, 16'h817E, 2};
    vecs[2] = '{16'h1234, 24'h550000, 1, 16'h5500, 1};
    vecs[3] = '{16'hFF01, 24'hC33C99, 3, 16'hC33C, 3};

    // reset state
    clk(4);
    check("rst_miso", miso, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_overflow", rx_overflow, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_frame_active", frame_active, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_short", frame_short, 0);
    check("rst_rx_timeout", rx_timeout, 0);
    reset = 1'b0;
    clk(6);
    check("post_rst_done", done_n, 0);

    // pop on empty FIFO is ignored
    rx_ready = 1'b1;
    clk(4);
    check("empty_pop_valid", rx_valid, 0);
    check("empty_pop_log", got_q.size(), 0);

    // table: two-word frames, rx_ready=1
    for (int v = 0; v < 4; v++) begin
      got_q.delete();
      t = vecs[v].tx_w;
      for (int k = 0; k < vecs[v].ntx; k++) txq.push_back(t[23-8*k -: 8]);
      clk(2);
      d0 = done_n; s0 = short_n; r0 = txr_n;
      run_frame(16, {48'h0, vecs[v].mosi_w}, mb);
      check($sformatf("v%0d_nwords", v), got_q.size(), 2);
      check($sformatf("v%0d_rx0", v), (got_q.size() > 0) ? got_q[0] : 8'hxx, vecs[v].mosi_w[15:8]);
      check($sformatf("v%0d_rx1", v), (got_q.size() > 1) ? got_q[1] : 8'hxx, vecs[v].mosi_w[7:0]);
      check($sformatf("v%0d_miso", v), mb[15:0], vecs[v].exp_miso);
      check($sformatf("v%0d_tx_ready", v), txr_n - r0, vecs[v].exp_txr);
      check($sformatf("v%0d_done", v), done_n - d0, 1);
      check($sformatf("v%0d_short", v), short_n - s0, 0);
      check($sformatf("v%0d_active_mid", v), fa_mid, 1);
      check($sformatf("v%0d_miso_idle", v), miso, 0);
      check($sformatf("v%0d_active_end", v), frame_active, 0);
      check($sformatf("v%0d_rx_valid_end", v), rx_valid, 0);
    end
    txq.delete();

    // overflow: six words with rx_ready=0
    rx_ready = 1'b0;
    got_q.delete();
    o0 = ovf_n;
    run_frame(48, 64'h0000_1122_3344_5566, mb);
    check("ovf_pulses", ovf_n - o0, 2);
    check("ovf_valid", rx_valid, 1);
    rx_ready = 1'b1;
    clk(8);
    rx_ready = 1'b0;
    check("ovf_drain_n", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("ovf_drain%0d", i), (got_q.size() > i) ? got_q[i] : 8'hxx, 8'h11 * (i + 1));
    check("ovf_empty", rx_valid, 0);

    // full FIFO: push with a single-cycle pop around it, no overflow
    got_q.delete();
    o0 = ovf_n;
    run_frame(32, 64'hA1B2C3D4, mb);
    cs_n = 1'b0;
    clk(H);
    t = 24'h0000E5;
    for (int i = 7; i >= 1; i--) send_bit(t[i], m);
    mosi = t[0];
    clk(H);
    sclk = 1'b1;
    clk(2);
    rx_ready = 1'b1;
    clk(1);
    rx_ready = 1'b0;
    clk(H - 3);
    sclk = 1'b0;
    clk(H);
    cs_n = 1'b1;
    clk(8);
    check("full_pp_ovf", ovf_n - o0, 0);
    check("full_pp_pop1", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'hA1);
    rx_ready = 1'b1;
    clk(8);
    rx_ready = 1'b0;
    check("full_pp_n", got_q.size(), 5);
    check("full_pp_w2", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'hB2);
    check("full_pp_w4", (got_q.size() > 3) ? got_q[3] : 8'hxx, 8'hD4);
    check("full_pp_w5", (got_q.size() > 4) ? got_q[4] : 8'hxx, 8'hE5);

    // latency from final sclk rise to rx_valid, FIFO empty
    got_q.delete();
    cs_n = 1'b0;
    clk(H);
    t = 24'h00003A;
    for (int i = 7; i >= 1; i--) send_bit(t[i], m);
    mosi = t[0];
    clk(H);
    sclk = 1'b1;
    lat = 0;
    while (!rx_valid && lat < 8) begin
      @(negedge clock);
      lat++;
    end
    check("latency_le5", (rx_valid && lat <= 5), 1);
    clk(H);
    sclk = 1'b0;
    clk(H);
    cs_n = 1'b1;
    check("latency_word", rx_data, 8'h3A);
    rx_ready = 1'b1;
    clk(8);

    // short frame: 11 bits, then an aligned frame
    got_q.delete();
    d0 = done_n; s0 = short_n;
    run_frame(11, {53'h0, 8'hC6, 3'b101}, mb);
    check("short_nwords", got_q.size(), 1);
    check("short_word", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'hC6);
    check("short_done", done_n - d0, 1);
    check("short_flag", short_n - s0, 1);
    got_q.delete();
    s0 = short_n;
    run_frame(8, 64'h5B, mb);
    check("aligned_word", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h5B);
    check("aligned_short", short_n - s0, 0);

    // reset mid-frame with cs_n held low
    got_q.delete();
    d0 = done_n; o0 = ovf_n; r0 = txr_n;
    cs_n = 1'b0;
    clk(H);
    for (int i = 0; i < 3; i++) send_bit(1'b1, m);
    reset = 1'b1;
    clk(2);
    check("midrst_active", frame_active, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1, m);
    clk(H);
    check("midrst_nwords", got_q.size(), 0);
    check("midrst_valid", rx_valid, 0);
    check("midrst_active2", frame_active, 0);
    cs_n = 1'b1;
    clk(8);
    check("midrst_done", done_n - d0, 0);
    check("midrst_ovf", ovf_n - o0, 0);
    check("midrst_txr", txr_n - r0, 0);
    d0 = done_n;
    run_frame(8, 64'h96, mb);
    check("midrst_next_word", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h96);
    check("midrst_next_done", done_n - d0, 1);

    check("no_timeout", to_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
